// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Raster timing generator for an ADV7123-style VGA DAC. Horizontal and
// vertical counters walk the full raster. A combinational counter stage
// issues pixel requests with active-area coordinates. Sync, vsync and
// active flags are delayed so that pixel data returned by a fixed-latency
// source lines up with the syncs on the DAC pins.
//
// Pixel-source contract: the colour for a request issued in enabled tick t
// must be present on i_r/i_g/i_b at the PIX_LAT-th enabled edge counted
// from (and including) the edge that closes tick t. The colour is then
// driven on VGA_R/G/B during enabled tick t+PIX_LAT.
module vga_timing_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_LAT  = 2,
    parameter int COLOR_W  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    output logic                        o_req,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic                        o_line_start,
    output logic                        o_frame_start,
    input  logic [COLOR_W-1:0]          i_r,
    input  logic [COLOR_W-1:0]          i_g,
    input  logic [COLOR_W-1:0]          i_b,
    output logic [COLOR_W-1:0]          VGA_R,
    output logic [COLOR_W-1:0]          VGA_G,
    output logic [COLOR_W-1:0]          VGA_B,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_BLANK_N,
    output logic                        VGA_SYNC_N
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int CW        = $clog2(MAX_TOTAL);
    localparam int CW1       = CW + 1;
    localparam int XW        = $clog2(H_ACTIVE);
    localparam int YW        = $clog2(V_ACTIVE);
    localparam int PD        = PIX_LAT - 1;

    // Last count of each axis before wrapping.
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // First active count of each axis, used for coordinate offsets.
    localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BACK);

    // Phase boundaries (exclusive ends), one bit wider than the counters
    // so an end equal to 2**CW still compares correctly.
    localparam logic [CW1-1:0] H_SYNC_END = CW1'(H_SYNC);
    localparam logic [CW1-1:0] H_BACK_END = CW1'(H_SYNC + H_BACK);
    localparam logic [CW1-1:0] H_ACT_END  = CW1'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CW1-1:0] V_SYNC_END = CW1'(V_SYNC);
    localparam logic [CW1-1:0] V_BACK_END = CW1'(V_SYNC + V_BACK);
    localparam logic [CW1-1:0] V_ACT_END  = CW1'(V_SYNC + V_BACK + V_ACTIVE);

    // Asserted level of each sync pin.
    localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

    // The fetch pipeline depth is only defined for 1..4 ticks.
    generate
        if ((PIX_LAT < 1) || (PIX_LAT > 4)) begin : g_bad_pix_lat
            $error("vga_timing_ctrl: PIX_LAT must be in the range 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Phase decode
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_e;

    // Map a counter value onto its raster phase (SYNC, BACK, ACTIVE, FRONT).
    function automatic phase_e phase_of(
        input logic [CW-1:0]  cnt,
        input logic [CW1-1:0] sync_end,
        input logic [CW1-1:0] back_end,
        input logic [CW1-1:0] act_end
    );
        logic [CW1-1:0] cnt_ext;
        phase_e         ph;
        cnt_ext = {1'b0, cnt};
        if (cnt_ext < sync_end) begin
            ph = PH_SYNC;
        end else if (cnt_ext < back_end) begin
            ph = PH_BACK;
        end else if (cnt_ext < act_end) begin
            ph = PH_ACTIVE;
        end else begin
            ph = PH_FRONT;
        end
        return ph;
    endfunction

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CW-1:0] h_cnt_q;
    logic [CW-1:0] h_cnt_d;
    logic [CW-1:0] v_cnt_q;
    logic [CW-1:0] v_cnt_d;

    // Next-state for the counters: h advances per tick, v on h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (i_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = {CW{1'b0}};
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = {CW{1'b0}};
                end else begin
                    v_cnt_d = v_cnt_q + CW'(1'b1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CW'(1'b1);
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Counter registers; reset puts the raster at the top-left of sync.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_q <= {CW{1'b0}};
            v_cnt_q <= {CW{1'b0}};
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Counter stage (stage 0)
    // ------------------------------------------------------------------
    phase_e     h_phase_s;
    phase_e     v_phase_s;
    logic       active_s;
    logic       hsync_s;
    logic       vsync_s;
    logic [2:0] stage0_s;
    logic [2:0] last_s;

    // Decode phases, request strobe, coordinates and start pulses.
    always_comb begin
        h_phase_s     = phase_of(h_cnt_q, H_SYNC_END, H_BACK_END, H_ACT_END);
        v_phase_s     = phase_of(v_cnt_q, V_SYNC_END, V_BACK_END, V_ACT_END);
        active_s      = (h_phase_s == PH_ACTIVE) && (v_phase_s == PH_ACTIVE);
        hsync_s       = (h_phase_s == PH_SYNC);
        vsync_s       = (v_phase_s == PH_SYNC);
        o_req         = i_en && active_s;
        o_line_start  = i_en && (h_cnt_q == {CW{1'b0}});
        o_frame_start = i_en && (h_cnt_q == {CW{1'b0}}) && (v_cnt_q == {CW{1'b0}});
        // Subtract at counter width, then truncate; outside the active
        // window the coordinates are forced to zero.
        if (active_s) begin
            o_x = XW'(h_cnt_q - H_ACT_START);
            o_y = YW'(v_cnt_q - V_ACT_START);
        end else begin
            o_x = {XW{1'b0}};
            o_y = {YW{1'b0}};
        end
    end

    // Flags carried down the display pipeline: {hsync, vsync, active}.
    assign stage0_s = {hsync_s, vsync_s, active_s};

    // ------------------------------------------------------------------
    // Display pipeline: PIX_LAT-1 delay stages, then the output registers
    // ------------------------------------------------------------------
    generate
        if (PD == 0) begin : g_no_delay
            assign last_s = stage0_s;
        end else begin : g_delay
            logic [2:0] dly_q [PD];

            // Shift the sync/active flags one stage per enabled tick.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int k = 0; k < PD; k++) begin
                        dly_q[k] <= 3'b000;
                    end
                end else if (i_en) begin
                    dly_q[0] <= stage0_s;
                    for (int k = 1; k < PD; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end

            assign last_s = dly_q[PD-1];
        end
    endgenerate

    logic [COLOR_W-1:0] vga_r_q;
    logic [COLOR_W-1:0] vga_g_q;
    logic [COLOR_W-1:0] vga_b_q;
    logic               vga_hs_q;
    logic               vga_vs_q;
    logic               vga_blank_n_q;

    // Final stage: capture colour when the aligned pixel is visible and
    // drive the syncs at their configured polarity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vga_r_q       <= {COLOR_W{1'b0}};
            vga_g_q       <= {COLOR_W{1'b0}};
            vga_b_q       <= {COLOR_W{1'b0}};
            vga_hs_q      <= ~HS_ON;
            vga_vs_q      <= ~VS_ON;
            vga_blank_n_q <= 1'b0;
        end else if (i_en) begin
            vga_hs_q      <= last_s[2] ? HS_ON : ~HS_ON;
            vga_vs_q      <= last_s[1] ? VS_ON : ~VS_ON;
            vga_blank_n_q <= last_s[0];
            if (last_s[0]) begin
                vga_r_q <= i_r;
                vga_g_q <= i_g;
                vga_b_q <= i_b;
            end else begin
                vga_r_q <= {COLOR_W{1'b0}};
                vga_g_q <= {COLOR_W{1'b0}};
                vga_b_q <= {COLOR_W{1'b0}};
            end
        end
    end

    assign VGA_R       = vga_r_q;
    assign VGA_G       = vga_g_q;
    assign VGA_B       = vga_b_q;
    assign VGA_HS      = vga_hs_q;
    assign VGA_VS      = vga_vs_q;
    assign VGA_BLANK_N = vga_blank_n_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl.
// DUT1: small raster (H 2/2/4/2, V 1/1/3/1, PIX_LAT=3, HS active-high,
// VS active-low) under randomized i_en and mid-frame resets, scoreboarded
// against a tick-count reference model.
// DUT2: default 640x480 timing with i_en tied high, checked for the
// first-active-pixel position and sync pulse widths.
module tb_vga_timing_ctrl;

    // ---------------- small raster geometry ----------------
    localparam int HS1 = 2, HB1 = 2, HA1 = 4, HF1 = 2;
    localparam int VS1 = 1, VB1 = 1, VA1 = 3, VF1 = 1;
    localparam int LAT1 = 3;
    localparam int HT1  = HS1 + HB1 + HA1 + HF1;
    localparam int VT1  = VS1 + VB1 + VA1 + VF1;
    localparam int HX0  = HS1 + HB1;
    localparam int VY0  = VS1 + VB1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT1 ----------------
    logic       i_rst_n = 1'b0;
    logic       i_en    = 1'b0;
    logic       o_req, o_line_start, o_frame_start;
    logic [1:0] o_x, o_y;
    logic [7:0] i_r, i_g, i_b, vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    vga_timing_ctrl #(
        .H_SYNC(HS1), .H_BACK(HB1), .H_ACTIVE(HA1), .H_FRONT(HF1),
        .V_SYNC(VS1), .V_BACK(VB1), .V_ACTIVE(VA1), .V_FRONT(VF1),
        .HS_POL(1), .VS_POL(0), .PIX_LAT(LAT1), .COLOR_W(8)
    ) dut1 (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .o_req(o_req), .o_x(o_x), .o_y(o_y),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n)
    );

    // ---------------- DUT2 (defaults) ----------------
    logic       rst2_n = 1'b0;
    logic       en2    = 1'b1;
    logic       req2, ls2, fs2;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [7:0] r2, g2, b2;
    logic       hs2, vs2, blank2, sync2;
    bit         dut2_done = 1'b0;

    vga_timing_ctrl dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_en(en2),
        .o_req(req2), .o_x(x2), .o_y(y2),
        .o_line_start(ls2), .o_frame_start(fs2),
        .i_r(8'h5A), .i_g(8'h5B), .i_b(8'h5C),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
        .VGA_HS(hs2), .VGA_VS(vs2),
        .VGA_BLANK_N(blank2), .VGA_SYNC_N(sync2)
    );

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       req, ls, fs;
        logic [1:0] x, y;
        logic [7:0] r, g, b;
        logic       hs, vs, blank;
    } exp_t;

    // Colour the bench's pixel source returns for coordinate (x, y).
    function automatic logic [23:0] pix(input int x, input int y);
        return {8'(x + 16 * y), 8'(8'hA0 + x), 8'(8'h50 + y)};
    endfunction

    function automatic bit in_act(input int h, input int v);
        return (h >= HX0) && (h < HX0 + HA1) && (v >= VY0) && (v < VY0 + VA1);
    endfunction

    // Expected outputs after n enabled ticks since reset, with i_en = en.
    function automatic exp_t model(input int n, input bit en);
        exp_t        e;
        int          h, v, hm, vm;
        logic [23:0] p;
        h       = n % HT1;
        v       = (n / HT1) % VT1;
        e.req   = en && in_act(h, v);
        e.x     = in_act(h, v) ? 2'(h - HX0) : 2'd0;
        e.y     = in_act(h, v) ? 2'(v - VY0) : 2'd0;
        e.ls    = en && (h == 0);
        e.fs    = en && (h == 0) && (v == 0);
        if (n < LAT1) begin
            p       = 24'd0;
            e.hs    = 1'b0;
            e.vs    = 1'b1;
            e.blank = 1'b0;
        end else begin
            hm      = (n - LAT1) % HT1;
            vm      = ((n - LAT1) / HT1) % VT1;
            e.hs    = (hm < HS1);
            e.vs    = !(vm < VS1);
            e.blank = in_act(hm, vm);
            p       = in_act(hm, vm) ? pix(hm - HX0, vm - VY0) : 24'd0;
        end
        {e.r, e.g, e.b} = p;
        return e;
    endfunction

    // ---------------- pixel source with PIX_LAT-1 register stages ----------------
    logic [23:0] src0 = 24'd0, src1 = 24'd0;
    always @(posedge clk) begin
        if (i_en) begin
            src0 <= o_req ? pix(int'(o_x), int'(o_y)) : 24'($urandom);
            src1 <= src0;
        end
    end
    assign {i_r, i_g, i_b} = src1;

    // ---------------- scoreboard ----------------
    exp_t sb[$];
    exp_t mon_e;
    int   n_ticks = 0;

    // Monitor: pop the expectation for this cycle and compare every output.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("o_req",         32'(o_req),         32'(mon_e.req));
            chk("o_x",           32'(o_x),           32'(mon_e.x));
            chk("o_y",           32'(o_y),           32'(mon_e.y));
            chk("o_line_start",  32'(o_line_start),  32'(mon_e.ls));
            chk("o_frame_start", 32'(o_frame_start), 32'(mon_e.fs));
            chk("VGA_R",         32'(vga_r),         32'(mon_e.r));
            chk("VGA_G",         32'(vga_g),         32'(mon_e.g));
            chk("VGA_B",         32'(vga_b),         32'(mon_e.b));
            chk("VGA_HS",        32'(vga_hs),        32'(mon_e.hs));
            chk("VGA_VS",        32'(vga_vs),        32'(mon_e.vs));
            chk("VGA_BLANK_N",   32'(vga_blank_n),   32'(mon_e.blank));
            chk("VGA_SYNC_N",    32'(vga_sync_n),    32'd0);
        end
    end

    // One cycle of stimulus: account for the edge just taken, drive new
    // inputs, and queue the expectation for the cycle that follows.
    task automatic step(input bit rst_v, input bit en_v);
        @(posedge clk);
        if (i_rst_n && i_en) n_ticks++;
        #1;
        i_rst_n = rst_v;
        i_en    = en_v;
        if (!rst_v) n_ticks = 0;
        sb.push_back(model(n_ticks, en_v));
    endtask

    // DUT1 stimulus and end of simulation.
    initial begin
        repeat (3) step(1'b0, 1'b0);
        repeat (130) step(1'b1, 1'b1);
        for (int i = 0; i < 140; i++) step(1'b1, (i % 2) == 0);
        repeat (400) step(1'b1, $urandom_range(0, 3) != 0);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(20, 90)) step(1'b1, $urandom_range(0, 2) != 0);
            repeat ($urandom_range(1, 3)) step(1'b0, $urandom_range(0, 1) == 0);
            repeat (150) step(1'b1, $urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        wait (dut2_done == 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // DUT2: default timing, i_en high; first request, blank and sync widths.
    initial begin : dut2_proc
        int k, first_req, first_blank, hs_low, vs_low;
        first_req = -1;
        first_blank = -1;
        hs_low = 0;
        vs_low = 0;
        k = 0;
        @(negedge clk);
        chk("d2_rst_hs", 32'(hs2), 32'd1);
        chk("d2_rst_vs", 32'(vs2), 32'd1);
        chk("d2_rst_blank", 32'(blank2), 32'd0);
        chk("d2_rst_req", 32'(req2), 32'd0);
        @(posedge clk);
        #1 rst2_n = 1'b1;
        while ((k < 30000) && (first_blank < 0)) begin
            @(negedge clk);
            if (k == 0) begin
                chk("d2_frame_start0", 32'(fs2), 32'd1);
                chk("d2_line_start0", 32'(ls2), 32'd1);
            end
            if ((k < 802) && (hs2 == 1'b0)) hs_low++;
            if (vs2 == 1'b0) vs_low++;
            if (req2 && (first_req < 0)) begin
                first_req = k;
                chk("d2_first_x", 32'(x2), 32'd0);
                chk("d2_first_y", 32'(y2), 32'd0);
            end
            if (blank2 && (first_blank < 0)) begin
                first_blank = k;
                chk("d2_first_r", 32'(r2), 32'h5A);
                chk("d2_first_b", 32'(b2), 32'h5C);
            end
            k++;
        end
        chk("d2_first_req_tick", 32'(first_req), 32'd28144);
        chk("d2_first_blank_tick", 32'(first_blank), 32'd28146);
        chk("d2_hs_low_width", 32'(hs_low), 32'd96);
        chk("d2_vs_low_width", 32'(vs_low), 32'd1600);
        dut2_done = 1'b1;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Parametrised VGA raster timing generator with pixel-fetch handshake. Sits between the frame-buffer/pixel-source logic and the ADV7123 VGA DAC pins. It walks a configurable horizontal/vertical raster and issues a pixel request with active-area coordinates ahead of display time. It then re-aligns the returned RGB with sync/blank through a PIX_LAT-deep pipeline, so any source with fixed read latency can drive the screen.

## Interface
- H_SYNC, 96: HS pulse width, pixel ticks
- H_BACK, 48: horizontal back porch
- H_ACTIVE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch
- V_SYNC, 2: VS pulse width, lines
- V_BACK, 33: vertical back porch
- V_ACTIVE, 480: visible lines
- V_FRONT, 10: vertical front porch
- HS_POL, 0: sync polarity, 0 = active-low, 1 = active-high
- VS_POL, 0: as HS_POL, vertical
- PIX_LAT, 2: enabled ticks from o_req to valid i_r/i_g/i_b; legal 1..4, others are an elaboration error
- COLOR_W, 8: bits per colour channel

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  pixel tick; all state advances only when high
- o_req  out  1  pixel request strobe, one cycle per active pixel
- o_x  out  $clog2(H_ACTIVE)  active column of current request
- o_y  out  $clog2(V_ACTIVE)  active row of current request
- o_line_start  out  1  one-tick pulse at h=0
- o_frame_start  out  1  one-tick pulse at h=0, v=0
- i_r, i_g, i_b  in  COLOR_W each  pixel data, sampled PIX_LAT ticks after o_req
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  DAC colour
- VGA_HS, VGA_VS  out  1  syncs, polarity per parameter
- VGA_BLANK_N  out  1  high only in visible area
- VGA_SYNC_N  out  1  tied 0

## Operation
- H_TOTAL = sum of H params; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1. Counters are sized $clog2 of the larger total.
- Phase order per axis: SYNC, BACK, ACTIVE, FRONT. The horizontal FSM states are derived from h_cnt boundaries, and the vertical FSM from v_cnt.
- On an i_en tick, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 after V_TOTAL-1 on the same tick as h wrap.
- Counter stage (stage 0) is decoded combinationally from the current counters:
  - active = h in ACTIVE && v in ACTIVE.
  - o_req = i_en && active.
  - o_x = h_cnt-(H_SYNC+H_BACK) when active, else 0. o_y likewise with V params.
  - o_line_start = i_en && h_cnt==0. o_frame_start additionally requires v_cnt==0.
- Display pipeline: hs, vs and active are delayed by PIX_LAT shift stages that advance only on i_en.
  - At the last stage, i_r/i_g/i_b are registered when the delayed active is 1, else 0.
  - VGA_HS = HS_POL when the delayed hsync is asserted, else ~HS_POL. VGA_VS likewise.
  - VGA_BLANK_N = delayed (h active AND v active); it is never high during a porch or sync on either axis.
- i_en low: counters, pipeline and all VGA_* outputs hold. o_req, o_line_start and o_frame_start are 0.

## Timing
- Reset (async assert; sync release on the next i_clk edge):
  - h_cnt=v_cnt=0; pipeline filled with blank and inactive sync.
  - VGA_R/G/B=0, VGA_BLANK_N=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - o_req=0, o_x=o_y=0, VGA_SYNC_N=0.
- The first enabled tick after release is h=0, v=0. It produces o_frame_start=1 and o_line_start=1, and the sync assertion enters the pipeline.
- VGA_* lag the counter stage by exactly PIX_LAT enabled ticks. The pixel requested at tick t appears on VGA_R/G/B at tick t+PIX_LAT.
- Reset mid-line: all outputs return to reset values within the same cycle. The raster restarts at h=0, v=0 with no partial pixels emitted.
- Simultaneous h wrap and v wrap on the last tick of the frame: the next tick is h=0, v=0 with o_frame_start.
- All subtraction for o_x/o_y is done at counter width, then truncated. Outside the active area the value is forced to 0, never a wrapped negative.

## Test plan
- Defaults, i_en=1 constantly:
  - VGA_HS low for 96 of every 800 cycles; VGA_VS low for 1600 cycles per 420000-cycle frame.
  - o_frame_start period is 420000.
- Defaults, first active pixel: o_req first rises 28144 enabled ticks after reset release, with o_x=0, o_y=0. VGA_BLANK_N first rises 2 ticks later.
- Small raster (H 2/2/4/2, V 1/1/3/1, PIX_LAT=3), i_rgb returns {x+16*y} with 3-tick latency:
  - VGA_R sequence per visible line is 16y..16y+3 for y=0..2.
  - BLANK_N is never high outside these 12 pixels.
- i_en=1 on every other cycle: all periods double. Outputs are bit-identical to the i_en=1 run when sampled on enabled ticks.
- HS_POL=1, VS_POL=1: sync pulses are active-high with the same widths. At reset VGA_HS=0 and VGA_VS=0.
- Reset asserted at h=300, v=100: outputs take reset values in the same cycle. After release the sequence matches a cold start from h=0, v=0.
